sys4_stream_loader: RTL and testbench

Streaming front/back end for the 4x4 `sys4` matrix-multiply block. It accepts A and B as a serial word stream over a valid/ready input, assembles them into the 256-bit `mm_a`/`mm_b` buses and pulses `mm_start`. It then waits for `mm_done`, captures `mm_c` and streams the 16 result words out over a valid/ready output. It sits directly between the DMA/host word stream and `sys4`, one job at a time.

---
 rtl/sys4_stream_loader.sv | 97 +++++++++
 tb/tb_sys4_stream_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sys4_stream_loader.sv
// Serial word front/back end for the 4x4 sys4 multiplier: loads A then B row-major,
// fires one job, captures C on done and streams the 16 result words back out.
module sys4_stream_loader #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH*16-1:0]   mm_a,
  output logic [WIDTH*16-1:0]   mm_b,
  output logic                  mm_start,
  input  logic [WIDTH*16-1:0]   mm_c,
  input  logic                  mm_done,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  typedef enum logic [2:0] {
    ST_LOAD_A,
    ST_LOAD_B,
    ST_FIRE,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  state_t                state;
  logic [3:0]            idx;
  logic [WIDTH*16-1:0]   c_reg;

  // Handshake: a word moves when valid && ready are both high at a rising edge;
  // ready never depends on valid, and valid/data hold until the transfer happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LOAD_A;
      idx   <= 4'd0;
      mm_a  <= '0;
      mm_b  <= '0;
      c_reg <= '0;
    end else begin
      case (state)
        ST_LOAD_A: begin
          if (in_valid) begin
            mm_a[idx*WIDTH +: WIDTH] <= in_data;
            idx <= idx + 4'd1;
            if (idx == 4'd15) state <= ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          if (in_valid) begin
            mm_b[idx*WIDTH +: WIDTH] <= in_data;
            idx <= idx + 4'd1;
            if (idx == 4'd15) state <= ST_FIRE;
          end
        end
        ST_FIRE: state <= ST_WAIT;
        // Done is only looked at after FIRE, so a sticky done from the last job
        // never captures C before the new start has been applied.
        ST_WAIT: begin
          if (mm_done) begin
            c_reg <= mm_c;
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            idx <= idx + 4'd1;
            if (idx == 4'd15) state <= ST_LOAD_A;
          end
        end
        default: begin
          state <= ST_LOAD_A;
          idx   <= 4'd0;
        end
      endcase
    end
  end

  // Control outputs decode the state register and are forced low during reset.
  always_comb begin
    in_ready  = !rst && ((state == ST_LOAD_A) || (state == ST_LOAD_B));
    mm_start  = !rst && (state == ST_FIRE);
    out_valid = !rst && (state == ST_DRAIN);
    busy      = !rst && !((state == ST_LOAD_A) && (idx == 4'd0));
    out_data  = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_data = c_reg[idx*WIDTH +: WIDTH];
      out_last = (idx == 4'd15);
    end
  end

endmodule

// File: tb/tb_sys4_stream_loader.sv
// Directed bench for sys4_stream_loader with a behavioural sys4 stand-in whose
// done latency and result can be steered per step.
module tb_sys4_stream_loader;

  localparam int W = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [W-1:0]    in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W*16-1:0] mm_a, mm_b, mm_c;
  logic            mm_start;
  logic            mm_done;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            out_last;
  logic            busy;

  int total = 0;
  int bad = 0;

  sys4_stream_loader #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mm_a(mm_a), .mm_b(mm_b), .mm_start(mm_start),
    .mm_c(mm_c), .mm_done(mm_done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // sys4 stand-in: delay 0 leaves done high (sticky) and updates C at the start edge.
  logic [W*16-1:0] mock_c = '0;
  logic            mock_done = 1'b0;
  int              mock_cnt = 0;
  int              mock_delay = 0;
  logic            mock_override = 1'b0;
  logic [W*16-1:0] override_vec = '0;

  function automatic logic [W*16-1:0] matmul(input logic [W*16-1:0] a, input logic [W*16-1:0] b);
    logic [W*16-1:0] c;
    logic [W-1:0]    acc;
    c = '0;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc + W'(a[(r*4+k)*W +: W] * b[(k*4+cc)*W +: W]);
        c[(r*4+cc)*W +: W] = acc;
      end
    return c;
  endfunction

  always @(posedge clk) begin
    if (mm_start) begin
      if (mock_delay == 0) begin
        mock_done <= 1'b1;
        mock_c    <= mock_override ? override_vec : matmul(mm_a, mm_b);
      end else begin
        mock_done <= 1'b0;
        mock_cnt  <= mock_delay;
      end
    end else if (mock_cnt > 0) begin
      mock_cnt <= mock_cnt - 1;
      if (mock_cnt == 1) begin
        mock_done <= 1'b1;
        mock_c    <= mock_override ? override_vec : matmul(mm_a, mm_b);
      end
    end
  end

  assign mm_c    = mock_c;
  assign mm_done = mock_done;

  task automatic chk(input string tag, input logic [W*16-1:0] obs, input logic [W*16-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_word(input logic [W-1:0] d, input bit gaps);
    bit acc;
    int n;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_job(input logic [W*16-1:0] a, input logic [W*16-1:0] b, input bit gaps);
    for (int i = 0; i < 16; i++) send_word(a[i*W +: W], gaps);
    for (int i = 0; i < 16; i++) send_word(b[i*W +: W], gaps);
  endtask

  // strict: first word must be valid in the first sampled cycle, then one per cycle.
  task automatic recv_job(input string tag, input logic [W*16-1:0] exp, input bit bp, input bit strict);
    int k, cyc, last_cyc;
    bit held;
    logic [W-1:0] held_data;
    k = 0; cyc = 0; last_cyc = -1; held = 1'b0; held_data = '0;
    while (k < 16 && cyc < 400) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (out_valid) begin
        if (held) chk({tag, "_stall_hold"}, out_data, held_data);
        if (out_ready) begin
          chk({tag, "_data"}, out_data, exp[k*W +: W]);
          chk({tag, "_last"}, out_last, (k == 15));
          if (strict) chk({tag, "_cycle"}, cyc, last_cyc + 1);
          last_cyc = cyc;
          k++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_data = out_data;
        end
      end else begin
        chk({tag, "_idle_in_ready"}, in_ready, 0);
        chk({tag, "_idle_out_data"}, out_data, 0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    if (k < 16) chk({tag, "_timeout"}, k, 16);
  endtask

  initial begin
    logic [W*16-1:0] a_id, a_two_id, a_twos, b_seq, b_threes;
    logic [W*16-1:0] e_seq, e_dbl, e_a000, e_24;
    int n;
    for (int i = 0; i < 16; i++) begin
      a_id[i*W +: W]       = (i / 4 == i % 4) ? W'(1) : W'(0);
      a_two_id[i*W +: W]   = (i / 4 == i % 4) ? W'(2) : W'(0);
      a_twos[i*W +: W]     = W'(2);
      b_seq[i*W +: W]      = W'(i + 1);
      b_threes[i*W +: W]   = W'(3);
      e_seq[i*W +: W]      = W'(i + 1);
      e_dbl[i*W +: W]      = W'(2 * (i + 1));
      e_a000[i*W +: W]     = W'(16'hA000 + i);
      e_24[i*W +: W]       = W'(16'h0018);
    end

    // Power-on reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mm_start", mm_start, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_mm_a", mm_a, 0);
    chk("post_rst_out_last", out_last, 0);
    @(posedge clk); #1;

    // Basic job: identity x 1..16, checking FIRE/WAIT timing
    mock_delay = 0;
    send_job(a_id, b_seq, 1'b0);
    @(negedge clk);
    chk("basic_start_t1", mm_start, 1);
    chk("basic_busy", busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("basic_start_t2", mm_start, 0);
    chk("basic_valid_t2", out_valid, 0);
    @(posedge clk); #1;
    recv_job("basic", e_seq, 1'b0, 1'b1);
    @(negedge clk);
    chk("basic_in_ready_after", in_ready, 1);
    chk("basic_busy_after", busy, 0);
    @(posedge clk); #1;

    // Backpressure on both sides
    send_job(a_id, b_seq, 1'b1);
    recv_job("bp", e_seq, 1'b1, 1'b0);

    // Delayed done with overridden C
    mock_delay = 5;
    mock_override = 1'b1;
    override_vec = e_a000;
    send_job(a_id, b_seq, 1'b0);
    recv_job("delay", e_a000, 1'b0, 1'b0);
    mock_override = 1'b0;
    mock_delay = 0;

    // Reset held for 3 cycles in the middle of DRAIN
    send_job(a_id, b_seq, 1'b0);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_reached", out_valid, 1);
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_mm_start", mm_start, 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_mm_a", mm_a, 0);
    chk("mid_rst_mm_b", mm_b, 0);
    chk("mid_rst_in_ready_after", in_ready, 1);
    chk("mid_rst_out_valid_after", out_valid, 0);
    @(posedge clk); #1;

    // Partial load (7 B words) then reset, then a fresh job
    for (int i = 0; i < 16; i++) send_word(a_id[i*W +: W], 1'b0);
    for (int i = 0; i < 7; i++) send_word(b_seq[i*W +: W], 1'b0);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    send_job(a_twos, b_threes, 1'b0);
    recv_job("partial", e_24, 1'b0, 1'b0);

    // Two consecutive jobs with done left sticky between them
    send_job(a_id, b_seq, 1'b0);
    recv_job("sticky1", e_seq, 1'b0, 1'b0);
    chk("sticky_done_high", mm_done, 1);
    send_job(a_two_id, b_seq, 1'b0);
    recv_job("sticky2", e_dbl, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
